// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, halt opcode and queue entry type for the fetch queue
//
// Contents:
//   PC_W          fetch PC width (word addressed)
//   INSTR_W       instruction width, opcode in instr[15:12]
//   HALT_OP       opcode that stops fetching
//   fetch_entry_t one queued {pc, instr} pair
//   is_halt()     opcode test used when an instruction is pushed

package fetch_pkg;

    localparam int PC_W    = 16;
    localparam int INSTR_W = 16;

    localparam logic [3:0] HALT_OP = 4'hF;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic is_halt(input logic [INSTR_W-1:0] instr);
        return instr[15:12] == HALT_OP;
    endfunction

endpackage

// File: rtl/fetchq_fifo.sv
// rtl/fetchq_fifo.sv - parameterised synchronous FIFO with push, pop, flush and occupancy
//
// Parameters:
//   DEPTH    entries, power of two, >= 2
//   WIDTH    entry width in bits
// Ports:
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous active-low reset; clears pointers, count and storage
//   i_push   write i_data at the tail
//   i_pop    drop the head entry
//   i_flush  empty the FIFO; overrides push and pop
//   i_data   tail write data
//   o_data   head entry (storage read at the read pointer)
//   o_count  occupancy, 0..DEPTH
//   o_empty  occupancy is zero
//   o_full   occupancy is DEPTH

module fetchq_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic                   i_flush,
    input  logic [WIDTH-1:0]       i_data,
    output logic [WIDTH-1:0]       o_data,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_empty,
    output logic                   o_full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    // Pointers are exactly log2(DEPTH) bits so they wrap without explicit modulo.
    // A push while full is only legal together with a pop; the write then lands in
    // the slot the head is vacating this same edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (i_push && !i_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!i_push && i_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == FULL_CNT);

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction prefetch queue: fetch PC, halt and branch redirect around fetchq_fifo
//
// Optional feature macro: FETCHQ_BYPASS_EN (empty-queue same-cycle bypass to decode)
//
// Parameters:
//   DEPTH          queue entries, power of two, >= 2
// Ports:
//   clk            pipeline clock, rising edge
//   reset          asynchronous active-low reset
//   imem_addr      instruction memory address (the fetch PC)
//   imem_rdata     combinational instruction read of imem_addr
//   stall          decode cannot accept this cycle
//   branch_taken   redirect from execute; flushes queue, beats push/pop/halt
//   branch_target  PC to fetch from after a redirect
//   out_valid      head entry valid
//   out_pc         head entry PC
//   out_instr      head entry instruction
//   fetch_halted   a halt opcode was pushed; no further fetch until a redirect
//   count          queue occupancy

module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic [PC_W-1:0]        imem_addr,
    input  logic [INSTR_W-1:0]     imem_rdata,
    input  logic                   stall,
    input  logic                   branch_taken,
    input  logic [PC_W-1:0]        branch_target,
    output logic                   out_valid,
    output logic [PC_W-1:0]        out_pc,
    output logic [INSTR_W-1:0]     out_instr,
    output logic                   fetch_halted,
    output logic [$clog2(DEPTH):0] count
);

    logic [PC_W-1:0] r_pc;
    logic            r_halted;

    fetch_entry_t w_new;
    fetch_entry_t w_head;
    fetch_entry_t w_out;
    logic         w_fifo_empty;
    logic         w_fifo_full;
    logic         w_fifo_push;
    logic         w_fifo_pop;
    logic         w_push;
    logic         w_pop;
    logic [$clog2(DEPTH):0] w_fifo_count;

    assign w_new = '{pc: r_pc, instr: imem_rdata};

`ifdef FETCHQ_BYPASS_EN
    // With nothing queued, the entry being fetched this cycle goes straight to decode.
    // This is written without w_push so out_valid does not loop back through w_pop.
    logic w_bypass;
    assign w_bypass  = w_fifo_empty && !r_halted && !branch_taken;
    assign out_valid = !w_fifo_empty || w_bypass;
    assign w_out     = w_bypass ? w_new : w_head;
`else
    assign out_valid = !w_fifo_empty;
    assign w_out     = w_head;
`endif

    assign w_pop  = out_valid && !stall && !branch_taken;
    assign w_push = !r_halted && !branch_taken && (!w_fifo_full || w_pop);

    // A pop seen while the FIFO is empty can only be a bypassed entry: it is consumed
    // directly and never stored.
    assign w_fifo_push = w_push && !(w_fifo_empty && w_pop);
    assign w_fifo_pop  = w_pop && !w_fifo_empty;

    fetchq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_push  (w_fifo_push),
        .i_pop   (w_fifo_pop),
        .i_flush (branch_taken),
        .i_data  (w_new),
        .o_data  (w_head),
        .o_count (w_fifo_count),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc     <= '0;
            r_halted <= 1'b0;
        end else if (branch_taken) begin
            r_pc     <= branch_target;
            r_halted <= 1'b0;
        end else if (w_push) begin
            r_pc <= r_pc + 1'b1;
            if (is_halt(imem_rdata)) begin
                r_halted <= 1'b1;
            end
        end
    end

    assign imem_addr    = r_pc;
    assign out_pc       = w_out.pc;
    assign out_instr    = w_out.instr;
    assign fetch_halted = r_halted;
    assign count        = w_fifo_count;

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction prefetch queue for the 16-bit five-stage pipeline. It owns the fetch PC, reads instruction memory, and buffers up to DEPTH `{pc, instr}` entries. It presents the oldest entry to the decode stage, which consumes it under the pipeline `stall` signal. It sits between instruction memory and the decode stage, absorbing decode stalls and discarding wrong-path instructions on a taken branch.

## Interface
- `DEPTH`, 4: queue entries; power of two, ≥2
- `PC_W`, 16: PC width; word-addressed
- `INSTR_W`, 16: instruction width; opcode is `instr[15:12]`
- `HALT_OP`, 4'hF: opcode that stops fetching

- `clk` input, 1: pipeline clock, rising edge
- `reset` input, 1: asynchronous, active-low
- `imem_addr` output, PC_W: instruction memory address, equal to the fetch PC
- `imem_rdata` input, INSTR_W: combinational read of `imem_addr`
- `stall` input, 1: decode cannot accept this cycle
- `branch_taken` input, 1: redirect from execute
- `branch_target` input, PC_W: redirect PC
- `out_valid` output, 1: head entry valid
- `out_pc` output, PC_W: head entry PC
- `out_instr` output, INSTR_W: head entry instruction
- `fetch_halted` output, 1: HALT_OP fetched; fetching stopped
- `count` output, $clog2(DEPTH)+1: occupancy

## Operation
- Reset values:
  - fetch PC = 0, queue empty, `count` = 0
  - `out_valid` = 0; `out_pc` and `out_instr` = 0
  - `fetch_halted` = 0
- Push condition: `!fetch_halted && !branch_taken && (count < DEPTH || pop)`.
- On push: enqueue `{PC, imem_rdata}`, then PC ← PC + 1, wrapping modulo 2^PC_W.
- Pop condition: `out_valid && !stall && !branch_taken`. A pop removes the head.
- Push and pop may occur in the same cycle, including when the queue is full. In that case `count` is unchanged.
- A pushed instruction with opcode == HALT_OP sets `fetch_halted`. That instruction is still enqueued; nothing after it is fetched.
- `branch_taken` has priority over push, pop and halt. Next cycle:
  - queue empty, `count` = 0
  - PC = `branch_target`
  - `fetch_halted` = 0
- Read and write pointers are $clog2(DEPTH) bits and wrap naturally.
- `out_*` show the head entry; they hold their value while `stall` = 1.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous). The first push happens on the first rising edge after deassertion.

## Timing
- Fetch-to-present latency is 1 cycle: an entry pushed at edge N is visible on `out_*` after edge N, provided it is the head.
- With the queue empty and no stall, decode receives one instruction per cycle, starting the cycle after reset deassertion.
- Branch redirect:
  - `branch_taken` at edge N: `out_valid` = 0 after N.
  - Target instruction pushed at N+1, presented after N+1.
  - Bubble of 1 cycle.
- Full queue with `stall` held: no push, PC frozen, `imem_addr` constant.
- `fetch_halted` rises after the edge that pushes the halt instruction. The queue then drains normally.

## Configuration
- `FETCHQ_BYPASS_EN`
  - Defined: when the queue is empty and a push occurs, `out_*` present `{PC, imem_rdata}` combinationally in the same cycle, with `out_valid` = 1. If that cycle also pops, the entry is not stored. Latency 0; the branch bubble remains 1 cycle.
  - Undefined: behaviour exactly as in Timing; all outputs are registered or taken from queue storage.

## Structure
- Shared package `fetch_pkg`: `HALT_OP`, `PC_W`, `INSTR_W`, and the `fetch_entry_t` typedef `{pc, instr}`.
- One sub-module, `fetchq_fifo`: a parameterised synchronous FIFO with push, pop and flush, plus an occupancy count. `fetch_queue` adds the PC, halt and redirect control around it.

## Test plan
- Reset then run with memory `0x1000..0x1007` at addresses 0–7, `stall` = 0 → `out_pc` 0,1,2,… on consecutive cycles from cycle 1; `count` ≤ 1.
- Hold `stall` = 1 for 10 cycles → `count` reaches 4, `imem_addr` freezes at 4. Release `stall` → `out_pc` continues 1,2,3,4,5 with no gap and no duplicate.
- With a full queue, pulse `branch_taken` with target 0x0020 → `out_valid` = 0 next cycle, `out_pc` = 0x20 the cycle after, `count` restarts at 1.
- Place `0xF000` at address 3 → `fetch_halted` rises after address 3 is pushed. Entries 0–3 drain and `out_valid` falls. A branch to 0x10 clears `fetch_halted` and resumes fetching.
- Assert reset mid-stream with 3 entries queued → `out_valid`, `count` and PC are 0 immediately, without waiting for a clock edge.
- Assert `stall` and `branch_taken` in the same cycle → flush wins, with no pop recorded. With `FETCHQ_BYPASS_EN` defined, the first post-reset instruction appears in cycle 0.
